// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_rx
// Purpose  : Receives PS/2 keyboard frames from the raw device clock/data
//            lines and turns them into the 11-bit ps2_key event word
//            {toggle, pressed, extended, code[7:0]}. Bit 10 toggles once per
//            key event so a consumer detects events by watching it change.
// Ports    : clk_sys   - system clock (only clock)
//            reset     - synchronous active-high reset
//            ps2_clk   - PS/2 clock line, asynchronous, idle high
//            ps2_dat   - PS/2 data line, asynchronous, idle high
//            ps2_key   - {toggle, pressed, extended, scan code}
//            frame_err - one-cycle pulse on a rejected or timed-out frame
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 3600
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] C_FLT_LAST = FW'(FILTER - 1);
    localparam logic [TW-1:0] C_TMO      = TW'(TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizers and clock glitch filter.
    // Everything resets to 1 so the lines read as idle after reset.
    // ------------------------------------------------------------------
    logic          r_clk_s1, r_clk_s2;
    logic          r_dat_s1, r_dat_s2;
    logic          r_fclk, r_fclk_d;
    logic [FW-1:0] r_fcnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_fclk   <= 1'b1;
            r_fclk_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
            r_fclk_d <= r_fclk;
            // fclk follows only after FILTER consecutive samples of a new level
            if (r_clk_s2 != r_fclk) begin
                if (r_fcnt == C_FLT_LAST) begin
                    r_fclk <= r_clk_s2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    logic w_fall;
    assign w_fall = r_fclk_d & ~r_fclk;

    // ------------------------------------------------------------------
    // Frame receiver and byte decode
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [3:0]    r_bitn;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_tcnt;
    logic          r_ext;
    logic          r_rel;
    logic [2:0]    r_skip;

    // Odd parity over data+parity, and the stop bit currently on the line
    logic w_frame_ok;
    assign w_frame_ok = (^{r_shift, r_par}) & r_dat_s2;

    // Keyboard housekeeping replies that carry no key information
    logic w_junk;
    always_comb begin
        w_junk = 1'b0;
        case (r_shift)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: w_junk = 1'b1;
            default:                                  w_junk = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bitn    <= 4'd0;
            r_shift   <= 8'd0;
            r_par     <= 1'b0;
            r_tcnt    <= '0;
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
            r_skip    <= 3'd0;
            ps2_key   <= 11'd0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tcnt <= '0;
                    if (w_fall) begin
                        if (!r_dat_s2) begin
                            r_state <= S_SHIFT;
                            r_bitn  <= 4'd1;
                        end else begin
                            // A clock edge without a start bit: out of sync
                            frame_err <= 1'b1;
                        end
                    end
                end

                S_SHIFT: begin
                    // An edge always beats a simultaneous timeout
                    if (w_fall) begin
                        r_tcnt <= '0;
                        if (r_bitn <= 4'd8) begin
                            r_shift <= {r_dat_s2, r_shift[7:1]};
                            r_bitn  <= r_bitn + 4'd1;
                        end else if (r_bitn == 4'd9) begin
                            r_par  <= r_dat_s2;
                            r_bitn <= 4'd10;
                        end else begin
                            r_state <= S_IDLE;
                            r_bitn  <= 4'd0;
                            if (!w_frame_ok) begin
                                r_ext     <= 1'b0;
                                r_rel     <= 1'b0;
                                frame_err <= 1'b1;
                            end else if (r_skip != 3'd0) begin
                                r_skip <= r_skip - 3'd1;
                            end else if (r_shift == 8'hE1) begin
                                // Pause key: swallow the remaining 7 bytes
                                r_skip <= 3'd7;
                            end else if (r_shift == 8'hE0) begin
                                r_ext <= 1'b1;
                            end else if (r_shift == 8'hF0) begin
                                r_rel <= 1'b1;
                            end else if (!(w_junk && !r_ext && !r_rel)) begin
                                ps2_key <= {~ps2_key[10], ~r_rel, r_ext, r_shift};
                                r_ext   <= 1'b0;
                                r_rel   <= 1'b0;
                            end
                        end
                    end else if (r_tcnt == C_TMO) begin
                        // Stalled frame: drop it but keep prefix/skip state
                        r_state   <= S_IDLE;
                        r_bitn    <= 4'd0;
                        r_shift   <= 8'd0;
                        r_tcnt    <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ps2_keyboard_rx
// Purpose  : Self-checking bench for ps2_keyboard_rx. A fixed vector table
//            covers the documented key sequences, hand-written sequences
//            cover filter, timeout and reset corner cases, and random frames
//            are checked against a byte-level keyboard model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_rx;

    localparam int FILTER  = 4;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 16;   // PS/2 half-period in clk_sys cycles
    localparam int GAP     = 48;   // idle cycles after each frame

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    ps2_keyboard_rx #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    // ---------------- output monitor ----------------
    int          evt_cnt  = 0;
    int          err_cnt  = 0;
    int          err_long = 0;
    bit          mon_en   = 1'b0;
    logic [10:0] prev_key;
    logic        prev_err = 1'b0;

    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (ps2_key !== prev_key) evt_cnt++;
            if (frame_err === 1'b1) begin
                err_cnt++;
                if (prev_err === 1'b1) err_long++;
            end
        end
        prev_key = ps2_key;
        prev_err = frame_err;
    end

    // ---------------- byte-level keyboard model ----------------
    logic [10:0] m_key;
    bit          m_ext, m_rel;
    int          m_skip;

    task automatic model_reset();
        m_key  = 11'd0;
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good,
                              output bit ev, output bit er);
        ev = 1'b0;
        er = 1'b0;
        if (!good) begin
            m_ext = 1'b0;
            m_rel = 1'b0;
            er    = 1'b1;
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (!m_ext && !m_rel &&
                     (b == 8'h00 || b == 8'hAA || b == 8'hEE ||
                      b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
            ev = 1'b0;
        end else begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            m_ext = 1'b0;
            m_rel = 1'b0;
            ev    = 1'b1;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic ps2_bit(input logic d);
        ps2_dat = d;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of a frame: start, data LSB first, parity, stop
    task automatic send_raw(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_raw(b, bad_par, bad_stop, 11);
        tick(GAP);
    endtask

    task automatic do_reset();
        mon_en  = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        reset   = 1'b1;
        tick(4);
        reset   = 1'b0;
        tick(2);
        model_reset();
        mon_en  = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst;
        logic [7:0]  b;
        bit          badp;
        bit          bads;
        logic [10:0] key;
        bit          ev;
        bit          er;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    logic [7:0] junk_codes [6];

    initial begin
        int e0, r0;
        bit ev, er;
        logic [7:0] b;
        bit bp, bs;
        int sel;

        tbl[0]  = '{1, 8'h1C, 0, 0, 11'h61C, 1, 0};
        tbl[1]  = '{1, 8'hF0, 0, 0, 11'h000, 0, 0};
        tbl[2]  = '{0, 8'h1C, 0, 0, 11'h41C, 1, 0};
        tbl[3]  = '{1, 8'hE0, 0, 0, 11'h000, 0, 0};
        tbl[4]  = '{0, 8'h75, 0, 0, 11'h775, 1, 0};
        tbl[5]  = '{0, 8'hE0, 0, 0, 11'h775, 0, 0};
        tbl[6]  = '{0, 8'hF0, 0, 0, 11'h775, 0, 0};
        tbl[7]  = '{0, 8'h75, 0, 0, 11'h175, 1, 0};
        tbl[8]  = '{0, 8'h1C, 1, 0, 11'h175, 0, 1};
        tbl[9]  = '{0, 8'hE0, 0, 0, 11'h175, 0, 0};
        tbl[10] = '{0, 8'h00, 1, 0, 11'h175, 0, 1};
        tbl[11] = '{0, 8'h75, 0, 0, 11'h675, 1, 0};
        tbl[12] = '{0, 8'hE1, 0, 0, 11'h675, 0, 0};
        tbl[13] = '{0, 8'h14, 0, 0, 11'h675, 0, 0};
        tbl[14] = '{0, 8'h77, 0, 0, 11'h675, 0, 0};
        tbl[15] = '{0, 8'hE1, 0, 0, 11'h675, 0, 0};
        tbl[16] = '{0, 8'hF0, 0, 0, 11'h675, 0, 0};
        tbl[17] = '{0, 8'h14, 0, 0, 11'h675, 0, 0};
        tbl[18] = '{0, 8'hF0, 0, 0, 11'h675, 0, 0};
        tbl[19] = '{0, 8'h77, 0, 0, 11'h675, 0, 0};
        tbl[20] = '{0, 8'h1C, 0, 0, 11'h21C, 1, 0};
        tbl[21] = '{0, 8'h1C, 0, 1, 11'h21C, 0, 1};

        junk_codes[0] = 8'h00; junk_codes[1] = 8'hAA; junk_codes[2] = 8'hEE;
        junk_codes[3] = 8'hFA; junk_codes[4] = 8'hFE; junk_codes[5] = 8'hFF;

        // Reset state
        do_reset();
        chk("reset_key", 32'(ps2_key), 32'h0);
        chk("reset_err", 32'(frame_err), 32'h0);

        // Table-driven sequences
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rst) do_reset();
            e0 = evt_cnt;
            r0 = err_cnt;
            send_frame(tbl[i].b, tbl[i].badp, tbl[i].bads);
            model_byte(tbl[i].b, !(tbl[i].badp || tbl[i].bads), ev, er);
            chk($sformatf("tbl%0d_key", i), 32'(ps2_key), 32'(tbl[i].key));
            chk($sformatf("tbl%0d_evt", i), 32'(evt_cnt - e0), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_err", i), 32'(err_cnt - r0), 32'(tbl[i].er));
        end

        // Clock glitch one cycle shorter than the filter is ignored
        e0 = evt_cnt;
        r0 = err_cnt;
        ps2_clk = 1'b0;
        tick(FILTER - 1);
        ps2_clk = 1'b1;
        tick(GAP);
        chk("glitch_err", 32'(err_cnt - r0), 32'h0);
        chk("glitch_evt", 32'(evt_cnt - e0), 32'h0);

        // A real falling edge with data high in idle is an error
        ps2_bit(1'b1);
        tick(GAP);
        chk("nostart_err", 32'(err_cnt - r0), 32'h1);
        chk("nostart_evt", 32'(evt_cnt - e0), 32'h0);

        // Timeout: 5 bits then silence
        e0 = evt_cnt;
        r0 = err_cnt;
        send_raw(8'h29, 0, 0, 5);
        tick(TIMEOUT - 2 * HALF);
        chk("tmo_early", 32'(err_cnt - r0), 32'h0);
        tick(2 * HALF + 10 + GAP);
        chk("tmo_err", 32'(err_cnt - r0), 32'h1);
        chk("tmo_evt", 32'(evt_cnt - e0), 32'h0);
        chk("tmo_key", 32'(ps2_key), 32'h21C);
        e0 = evt_cnt;
        send_frame(8'h29, 0, 0);
        model_byte(8'h29, 1'b1, ev, er);
        chk("tmo_next_key", 32'(ps2_key), 32'(m_key));
        chk("tmo_next_evt", 32'(evt_cnt - e0), 32'h1);

        // Reset in the middle of a frame
        send_raw(8'h1C, 0, 0, 7);
        mon_en = 1'b0;
        reset  = 1'b1;
        tick(3);
        reset  = 1'b0;
        tick(1);
        mon_en = 1'b1;
        e0 = evt_cnt;
        r0 = err_cnt;
        tick(GAP);
        model_reset();
        chk("midrst_key", 32'(ps2_key), 32'h0);
        chk("midrst_evt", 32'(evt_cnt - e0), 32'h0);
        chk("midrst_err", 32'(err_cnt - r0), 32'h0);
        send_frame(8'h1C, 0, 0);
        model_byte(8'h1C, 1'b1, ev, er);
        chk("midrst_next_key", 32'(ps2_key), 32'h61C);

        // Random frames against the model
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hE0;
                3: b = junk_codes[$urandom_range(0, 5)];
                default: b = 8'($urandom_range(0, 255));
            endcase
            sel = int'($urandom_range(0, 11));
            bp  = (sel == 0);
            bs  = (sel == 1);
            e0 = evt_cnt;
            r0 = err_cnt;
            send_frame(b, bp, bs);
            model_byte(b, !(bp || bs), ev, er);
            chk($sformatf("rnd%0d_key", i), 32'(ps2_key), 32'(m_key));
            chk($sformatf("rnd%0d_evt", i), 32'(evt_cnt - e0), 32'(ev));
            chk($sformatf("rnd%0d_err", i), 32'(err_cnt - r0), 32'(er));
        end

        chk("err_pulse_width", 32'(err_long), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
